serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter that produces the single-bit serial stream a downstream `din`-sampling capture stage consumes.
- Accepts a DATA_W-bit word over a valid/ready handshake.
- Emits the frame LSB-first: start bit (0), data bits, optional parity bit, stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks. Used as a stimulus-side DUT in the team's UVM environments.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = insert parity bit after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  asynchronous, active-low reset (asserted when 0)
tx_valid  input  1  upstream word available
tx_data  input  DATA_W  word to transmit; sampled only on handshake
tx_ready  output  1  block can accept a word this cycle
dout  output  1  serial line; idles high
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, dout=1, tx_ready=1, busy=0, done=0.
  - Shift register and all counters cleared.
- Reset mid-frame: the frame is abandoned immediately. dout returns high at once (asynchronously), no done pulse, and the word is lost.
- Handshake:
  - tx_ready = (state==IDLE), decoded combinationally from the state register.
  - Transfer occurs when tx_valid && tx_ready on a posedge. tx_data is latched into the shift register and parity is computed from the latched word.
  - tx_valid while tx_ready=0 is ignored; the upstream must hold the word.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Latency: the START bit appears on dout the cycle after the transfer.
- Bit timing:
  - A baud counter counts 0..CLKS_PER_BIT-1. A bit ends when the counter reaches CLKS_PER_BIT-1, and the counter then reloads to 0.
  - CLKS_PER_BIT=1 is legal: one bit per clock.
- dout per state:
  - IDLE=1, START=0.
  - DATA = shift register bit 0, shifted right at each bit end.
  - PARITY = parity bit: XOR of data for even parity, XNOR for odd.
  - STOP=1.
- DATA: the bit counter counts 0..DATA_W-1. After bit DATA_W-1 ends, go to PARITY or STOP.
- STOP: done=1 in its last cycle, then go to IDLE.
- Frame length: (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles from START entry through STOP end.
- Back-to-back: tx_ready rises in the IDLE cycle following STOP. With tx_valid already high, the next word is accepted in that cycle, so there is exactly one idle-high cycle between frames.
- dout, busy and done are registered or decoded from registers only; no combinational path from tx_valid/tx_data to dout.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT), minimum 1.
  - Bit counter: $clog2(DATA_W), minimum 1.
  - No wrap-around beyond terminal counts.

Decomposition:
- Package serial_frame_pkg:
  - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t.
  - Constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1.
  - The package is shared with the future matching receiver.
- Sub-module bit_timer:
  - Holds the baud counter with clear/enable.
  - Outputs a bit_end strobe.
  - Parameterised by CLKS_PER_BIT.
- Interface serial_frame_tx_if:
  - Bundles all ports for UVM driver/monitor binding.

Test Plan:
- Reset then idle, rst=0 for 3 cycles then 1 -> dout=1, tx_ready=1, busy=0, done=0 throughout, with no tx_valid.
- Single frame, defaults, tx_data=8'hA5 -> dout sequence 0,1,0,1,0,0,1,0,1,0(parity even),1, each held 4 cycles. Total 44 cycles, done high on cycle 44 only.
- Odd parity, PARITY_ODD=1, tx_data=8'h00 -> parity bit=1. PARITY_EN=0, tx_data=8'hFF -> 10-bit frame of 40 cycles, no parity slot.
- Back-to-back, tx_valid held with 8'h3C then 8'hC3 -> second accepted in the IDLE cycle after done, exactly one dout=1 gap cycle. Data changes while busy have no effect on dout.
- Reset mid-frame, rst=0 during DATA bit 3 of 8'h5A -> dout=1 immediately with no clock edge needed, no done pulse, tx_ready=1 after release. A new 8'h81 frame then transmits correctly.
- CLKS_PER_BIT=1, tx_data=8'h01 -> 11-cycle frame 0,1,0,0,0,0,0,0,0,1(parity),1. done on the 11th cycle.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: frame state encoding, line levels and counter sizing shared by tx and rx
package serial_frame_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: port bundle for driver/monitor binding
interface serial_frame_tx_if #(parameter int DATA_W = 8) (input logic clk, input logic rst);
  logic tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic tx_ready;
  logic dout;
  logic busy;
  logic done;
  modport dut (input clk, rst, tx_valid, tx_data, output tx_ready, dout, busy, done);
  modport mon (input clk, rst, tx_valid, tx_data, tx_ready, dout, busy, done);
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: baud counter that strobes bit_end in the last clock of each serial bit
module bit_timer import serial_frame_pkg::*; #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign bit_end = en && (cnt == LAST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= bit_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: valid/ready word in, LSB-first start/data/parity/stop frame out on dout
module serial_frame_tx import serial_frame_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic tx_ready,
  output logic dout,
  output logic busy,
  output logic done
);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  tx_state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic par;
  logic [BW-1:0] bcnt;
  logic bit_end;
  logic accept;
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = tx_valid && tx_ready;
  assign done = state == STOP && bit_end;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en(busy),
    .bit_end(bit_end)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? START : IDLE;
      START:   state_nx = bit_end ? DATA : START;
      DATA:    state_nx = (bit_end && bcnt == LAST_BIT) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
      PARITY:  state_nx = bit_end ? STOP : PARITY;
      STOP:    state_nx = bit_end ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    dout = state == START  ? START_LVL :
           state == DATA   ? sr[0] :
           state == PARITY ? par :
           state == STOP   ? STOP_LVL : LINE_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sr <= '0;
      par <= 1'b0;
      bcnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sr <= tx_data;
        par <= (^tx_data) ^ (PARITY_ODD != 0);
      end
      if (state == DATA && bit_end) begin
        sr <= sr >> 1;
        bcnt <= bcnt == LAST_BIT ? '0 : bcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: four parameter variants driven by directed steps against a frame scoreboard
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] tv = '0;
  logic [7:0] td [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [3:0] rdy, dout_w, bsy, dn;
  int tests = 0;
  int fails = 0;
  int cpb_t [4] = '{4, 4, 4, 1};
  int pe_t [4] = '{1, 1, 0, 1};
  int po_t [4] = '{0, 1, 0, 0};
  typedef struct packed {logic d; logic dn; logic bs;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(8)) sif (.clk(clk), .rst(rst));
  assign sif.tx_valid = tv[0];
  assign sif.tx_data = td[0];
  assign rdy[0] = sif.tx_ready;
  assign dout_w[0] = sif.dout;
  assign bsy[0] = sif.busy;
  assign dn[0] = sif.done;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .tx_valid(sif.tx_valid), .tx_data(sif.tx_data),
    .tx_ready(sif.tx_ready), .dout(sif.dout), .busy(sif.busy), .done(sif.done));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tv[1]), .tx_data(td[1]),
    .tx_ready(rdy[1]), .dout(dout_w[1]), .busy(bsy[1]), .done(dn[1]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tv[2]), .tx_data(td[2]),
    .tx_ready(rdy[2]), .dout(dout_w[2]), .busy(bsy[2]), .done(dn[2]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) dut3 (
    .clk(clk), .rst(rst), .tx_valid(tv[3]), .tx_data(td[3]),
    .tx_ready(rdy[3]), .dout(dout_w[3]), .busy(bsy[3]), .done(dn[3]));

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s dut%0d got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic push_bit(input int k, input logic b, input logic last);
    for (int r = 0; r < cpb_t[k]; r++) q.push_back('{b, last && r == cpb_t[k] - 1, 1'b1});
  endtask

  task automatic push_frame(input int k, input logic [7:0] d);
    push_bit(k, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(k, d[i], 1'b0);
    if (pe_t[k] != 0) push_bit(k, (^d) ^ (po_t[k] != 0), 1'b0);
    push_bit(k, 1'b1, 1'b1);
    q.push_back('{1'b1, 1'b0, 1'b0});
  endtask

  task automatic send(input int k, input logic [7:0] d, input bit hold);
    @(negedge clk);
    chk("ready_before_send", k, rdy[k], 1);
    tv[k] = 1'b1;
    td[k] = d;
    push_frame(k, d);
    @(posedge clk);
    #1 if (!hold) tv[k] = 1'b0;
  endtask

  task automatic drain(input int k, input int n);
    exp_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      @(negedge clk);
      e = q.pop_front();
      chk("dout", k, dout_w[k], e.d);
      chk("done", k, dn[k], e.dn);
      chk("busy", k, bsy[k], e.bs);
      chk("tx_ready", k, rdy[k], !e.bs);
      if (!e.bs && tv[k]) begin
        @(posedge clk);
        #1 tv[k] = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("rst_dout", 0, dout_w, 4'hF);
      chk("rst_ready", 0, rdy, 4'hF);
      chk("rst_busy", 0, bsy, 4'h0);
      chk("rst_done", 0, dn, 4'h0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_dout", 0, dout_w, 4'hF);
      chk("idle_busy", 0, bsy, 4'h0);
      chk("idle_done", 0, dn, 4'h0);
    end
    send(0, 8'hA5, 1'b0);
    drain(0, 1000);
    send(1, 8'h00, 1'b0);
    drain(1, 1000);
    send(2, 8'hFF, 1'b0);
    drain(2, 1000);
    send(3, 8'h01, 1'b0);
    drain(3, 1000);
    send(0, 8'h3C, 1'b1);
    td[0] = 8'hC3;
    push_frame(0, 8'hC3);
    drain(0, 1000);
    send(0, 8'h5A, 1'b0);
    drain(0, 17);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dout", 0, dout_w[0], 1);
    chk("midrst_busy", 0, bsy[0], 0);
    chk("midrst_ready", 0, rdy[0], 1);
    chk("midrst_done", 0, dn[0], 0);
    q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("midrst_hold_done", 0, dn[0], 0);
      chk("midrst_hold_dout", 0, dout_w[0], 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 0, rdy[0], 1);
    chk("post_rst_done", 0, dn[0], 0);
    send(0, 8'h81, 1'b0);
    drain(0, 1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
